// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into a single
// word-addressed bus transaction, stalls the pipeline while it is outstanding.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  ResultSrcM,
  input  logic        memwriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  lo_q, lo_d;
  logic [2:0]  f3_q, f3_d;

  logic        access, illegal, misaligned, bad;
  logic        stall_c, misalign_c, bus_err_c, timeout_hit;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c, load_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    access  = memwriteM | (ResultSrcM == 2'b01);
    illegal = (funct3M == 3'b011) | (funct3M == 3'b110) | (funct3M == 3'b111);
    case (funct3M[1:0])
      2'b01:   misaligned = ALUResultM[0];
      2'b10:   misaligned = (ALUResultM[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    bad = illegal | misaligned;

    // Store data is replicated across lanes so the strobes alone pick the bytes.
    case (funct3M[1:0])
      2'b00: begin
        strb_c  = 4'b0001 << ALUResultM[1:0];
        wdata_c = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        strb_c  = 4'b0011 << ALUResultM[1:0];
        wdata_c = {2{WriteDataM[15:0]}};
      end
      default: begin
        strb_c  = 4'b1111;
        wdata_c = WriteDataM;
      end
    endcase
  end

  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_c = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_c = {24'd0, byte_sel};
      3'b001:  load_c = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_c = {16'd0, half_sel};
      default: load_c = bus_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    lo_d       = lo_q;
    f3_d       = f3_q;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    bus_err_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && bad) begin
          misalign_c = 1'b1;
          if (!memwriteM) rdata_d = 32'd0;
        end else if (access) begin
          stall_c = 1'b1;
          state_d = S_BUSY;
          cnt_d   = 32'd0;
          req_d   = 1'b1;
          we_d    = memwriteM;
          addr_d  = {ALUResultM[31:2], 2'b00};
          wdata_d = wdata_c;
          wstrb_d = memwriteM ? strb_c : 4'b0000;
          lo_d    = ALUResultM[1:0];
          f3_d    = funct3M;
        end
      end
      S_BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        if (bus_ready) begin
          rdata_d = load_c;
          req_d   = 1'b0;
          state_d = S_DONE;
          cnt_d   = 32'd0;
        end else if (timeout_hit) begin
          bus_err_c = 1'b1;
          rdata_d   = 32'd0;
          req_d     = 1'b0;
          state_d   = S_DONE;
          cnt_d     = 32'd0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      rdata_q <= 32'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      lo_q    <= 2'd0;
      f3_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
    end
  end

  // Combinational flags are masked during reset so the pipeline is released at once.
  assign StallM       = stall_c & ~reset;
  assign misalign_err = misalign_c & ~reset;
  assign bus_err      = bus_err_c & ~reset;
  assign ReadDataM    = rdata_q;
  assign bus_req      = req_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_wstrb    = wstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised bench for mem_stage_lsu against a transaction-level model of
// the load/store rules (lanes, extension, alignment, timeout, stall count).
module tb_mem_stage_lsu;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ResultSrcM;
  logic        memwriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, misalign_err, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;
  int txn = 0;
  logic [31:0] rd_hold = 32'd0;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .ResultSrcM(ResultSrcM), .memwriteM(memwriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .misalign_err(misalign_err),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * lo)) & 32'hFF;
    h = (rd >> (16 * lo[1])) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  task automatic idle_cycle();
    memwriteM  = 1'b0;
    ResultSrcM = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
    funct3M    = 3'($urandom);
    ALUResultM = $urandom;
    bus_ready  = 1'($urandom);
    bus_rdata  = $urandom;
    #1;
    check_val("idle_stall", 32'(StallM), 32'd0);
    check_val("idle_req", 32'(bus_req), 32'd0);
    check_val("idle_misalign", 32'(misalign_err), 32'd0);
    @(posedge clock); @(negedge clock);
    check_val("idle_rdata_hold", ReadDataM, rd_hold);
  endtask

  // Starts and ends on a falling edge.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int waits,
                            input logic both);
    logic [1:0]  lo;
    logic        bad, timed, rdy;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    int          k, stalls;
    lo  = addr[1:0];
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
          ((f3[1:0] == 2'd1) && lo[0]) || ((f3[1:0] == 2'd2) && (lo != 2'd0));
    case (f3[1:0])
      2'd0:    begin exp_strb = 4'(1 << lo); exp_wdata = {4{wd[7:0]}}; end
      2'd1:    begin exp_strb = 4'(3 << lo); exp_wdata = {2{wd[15:0]}}; end
      default: begin exp_strb = 4'hF;        exp_wdata = wd;           end
    endcase
    if (!st) exp_strb = 4'h0;
    txn++;
    memwriteM  = st;
    ResultSrcM = (!st || both) ? 2'b01 : 2'b00;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    bus_ready  = 1'b0;
    bus_rdata  = $urandom;
    #1;
    check_val("misalign_err", 32'(misalign_err), 32'(bad));
    check_val("stall_first", 32'(StallM), 32'(!bad));
    stalls = StallM ? 1 : 0;
    @(posedge clock); @(negedge clock);
    if (bad) begin
      check_val("bad_no_req", 32'(bus_req), 32'd0);
      if (!st) rd_hold = 32'd0;
      $display("txn %0d st=%0b f3=%0d addr=%h rejected", txn, st, f3, addr);
      return;
    end
    k = 0;
    timed = 1'b0;
    rdy = 1'b0;
    while (!rdy && !timed && k < 64) begin
      k++;
      rdy       = (k > waits);
      bus_ready = rdy;
      bus_rdata = rdy ? rd : $urandom;
      #1;
      check_val("busy_req", 32'(bus_req), 32'd1);
      check_val("busy_stall", 32'(StallM), 32'd1);
      check_val("busy_addr", bus_addr, {addr[31:2], 2'b00});
      check_val("busy_we", 32'(bus_we), 32'(st));
      check_val("busy_wstrb", 32'(bus_wstrb), 32'(exp_strb));
      if (st) check_val("busy_wdata", bus_wdata, exp_wdata);
      timed = !rdy && (k == TO);
      check_val("busy_bus_err", 32'(bus_err), 32'(timed));
      if (StallM) stalls++;
      @(posedge clock); @(negedge clock);
    end
    bus_ready = 1'b0;
    if (timed) rd_hold = 32'd0;
    else       rd_hold = model_load(f3, lo, rd);
    #1;
    check_val("done_req", 32'(bus_req), 32'd0);
    check_val("done_stall", 32'(StallM), 32'd0);
    check_val("done_bus_err", 32'(bus_err), 32'd0);
    check_val("done_rdata", ReadDataM, rd_hold);
    check_val("stall_cycles", 32'(stalls), 32'(timed ? TO + 1 : waits + 2));
    @(posedge clock); @(negedge clock);
    $display("txn %0d st=%0b f3=%0d addr=%h waits=%0d timeout=%0b rdata=%h", txn, st, f3,
             addr, waits, timed, ReadDataM);
  endtask

  initial begin
    reset = 1'b1; memwriteM = 1'b0; ResultSrcM = 2'b00; funct3M = 3'd0;
    ALUResultM = 32'd0; WriteDataM = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
    @(negedge clock); @(negedge clock);
    #1;
    check_val("rst_rdata", ReadDataM, 32'd0);
    check_val("rst_req", 32'(bus_req), 32'd0);
    check_val("rst_addr", bus_addr, 32'd0);
    check_val("rst_wdata", bus_wdata, 32'd0);
    check_val("rst_flags", {26'd0, StallM, misalign_err, bus_err, bus_we, 2'b00},
              32'd0);
    check_val("rst_wstrb", 32'(bus_wstrb), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle_cycle();

    run_access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1'b0);
    run_access(1'b1, 3'b000, 32'h203, 32'h0000_00A5, 32'h1234_5678, 3, 1'b0);
    run_access(1'b0, 3'b000, 32'h2, 32'd0, 32'h0080_FF00, 0, 1'b0);
    run_access(1'b0, 3'b100, 32'h2, 32'd0, 32'h0080_FF00, 1, 1'b0);
    run_access(1'b0, 3'b001, 32'h3, 32'd0, 32'd0, 0, 1'b0);
    run_access(1'b1, 3'b010, 32'h6, 32'hCAFE_F00D, 32'd0, 0, 1'b0);
    idle_cycle();
    run_access(1'b0, 3'b010, 32'h40, 32'd0, 32'h5555_AAAA, 10, 1'b0);

    // Reset during the second BUSY cycle.
    memwriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h80;
    bus_ready = 1'b0;
    @(posedge clock); @(negedge clock);
    @(posedge clock); @(negedge clock);
    reset = 1'b1;
    #1;
    check_val("midrst_req", 32'(bus_req), 32'd0);
    check_val("midrst_stall", 32'(StallM), 32'd0);
    check_val("midrst_bus_err", 32'(bus_err), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    rd_hold = 32'd0;
    check_val("midrst_rdata", ReadDataM, rd_hold);
    idle_cycle();
    run_access(1'b0, 3'b010, 32'h84, 32'd0, 32'h0BAD_CAFE, 1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 $urandom_range(0, 5), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the pipelined RV32I core. Consumes the EX/MEM control outputs (memwriteM, ResultSrcM) plus the registered ALU result, store data and funct3. Drives a word-addressed data-bus request/ready handshake, and returns sign/zero-extended load data to the MEM/WB register. Holds the pipeline with StallM while a bus access is outstanding, and flags misaligned, illegal or timed-out accesses.

## Interface
- TIMEOUT, default 16: maximum BUSY cycles waiting for bus_ready; 0 disables the timeout.
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- ResultSrcM  input  2  result select from EX/MEM; 2'b01 = load
- memwriteM  input  1  store request from EX/MEM
- funct3M  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ALUResultM  input  32  byte address
- WriteDataM  input  32  store data (rs2)
- ReadDataM  output  32  extended load data, valid in DONE
- StallM  output  1  hold IF/ID/EX/MEM registers
- misalign_err  output  1  one-cycle pulse, misaligned or illegal funct3
- bus_err  output  1  one-cycle pulse, timeout
- bus_req  output  1  registered request
- bus_we  output  1  write enable, valid with bus_req
- bus_addr  output  32  word address {ALUResultM[31:2],2'b00}, latched
- bus_wdata  output  32  lane-replicated store data, latched
- bus_wstrb  output  4  byte strobes; 0 for loads
- bus_ready  input  1  bus completion, sampled in BUSY
- bus_rdata  input  32  read word, valid with bus_ready

## Operation
- access = memwriteM | (ResultSrcM == 2'b01); memwriteM takes priority if both are set (store).
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. Illegal funct3: 011, 110, 111.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no access: StallM=0, no bus activity.
- IDLE, access, misaligned or illegal:
  - misalign_err=1 for this cycle.
  - No bus request; the store is suppressed and the load returns 0.
  - StallM=0; stay in IDLE.
- IDLE, legal access:
  - StallM=1.
  - Latch bus_we, bus_addr, bus_wdata, bus_wstrb, addr[1:0] and funct3.
  - Go to BUSY; bus_req=1 from the next cycle.
- BUSY:
  - StallM=1, bus_req=1, fields stable.
  - The timeout counter increments each cycle.
  - bus_ready=1: capture the extended rdata into ReadDataM and go to DONE.
  - Counter reaches TIMEOUT-1 with no ready (TIMEOUT≠0): bus_err pulse, ReadDataM=0, go to DONE.
- DONE:
  - bus_req=0, StallM=0, so the pipeline advances this edge.
  - ReadDataM stays valid for MEM/WB capture.
  - Next state IDLE; counter cleared.
- Store strobes:
  - SB: 4'b0001<<addr[1:0], wdata={4{byte}}.
  - SH: 4'b0011<<addr[1:0], wdata={2{half}}.
  - SW: 4'b1111.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- ReadDataM holds its last value outside DONE.

## Timing
- Reset values: state IDLE; ReadDataM=0, StallM=0, misalign_err=0, bus_err=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0; counter=0.
- StallM and misalign_err are combinational from the state and inputs. Bus outputs and ReadDataM are registered.
- Minimum access: IDLE (stall) → BUSY with ready → DONE. The instruction occupies MEM for 3 cycles, with 2 stall cycles.
- Each additional wait cycle in BUSY adds one stall cycle.
- bus_req stays high until the cycle after bus_ready is sampled; a ready outside BUSY is ignored.
- A new instruction in MEM during DONE is not examined; evaluation resumes in IDLE on the next cycle.
- Reset mid-access (BUSY or DONE): immediate return to IDLE with bus_req=0 and the counter cleared. No completion, no bus_err, no ReadDataM update.
- Timeout with TIMEOUT=N: bus_err is asserted with the transition out of BUSY on its N-th cycle.

## Test plan
- LW at 0x100, bus_ready in the first BUSY cycle with rdata=0xDEADBEEF → bus_addr=0x100, wstrb=0, StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- SB at 0x203 with WriteDataM=0x000000A5, ready after 3 wait cycles → wstrb=4'b1000, wdata=0xA5A5A5A5, bus_addr=0x200, StallM high 5 cycles.
- LB at 0x2 and LBU at 0x2, rdata=0x0080FF00 → ReadDataM=0xFFFFFF80 and 0x00000080 respectively.
- LH at 0x3 and SW at 0x6 → misalign_err pulse each, bus_req stays 0, StallM 0.
- TIMEOUT=4, LW with bus_ready held 0 → bus_err pulse on the 4th BUSY cycle, ReadDataM=0, StallM drops in DONE.
- Reset asserted during the 2nd BUSY cycle → bus_req=0 and StallM=0 immediately. After release, a fresh LW completes normally.
